// File: rtl/stack_commit_if.sv
// Bundle between the block mover / intersection checker and stack_commit.
// master drives the stop request, moving block and checker result; slave is stack_commit.
interface stack_commit_if;
   logic       stop_pulse;
   logic [8:0] curr_block_start;
   logic [8:0] curr_block_end;
   logic [3:0] curr_block_size;
   logic       intersect_true;
   logic       stop_true;
   logic [8:0] prev_block_start;
   logic [8:0] prev_block_end;
   logic [3:0] prev_block_size;
   logic [3:0] row;
   logic [3:0] next_size;
   logic       next_valid;
   logic       busy;
   logic       game_over;
   logic       win;

   modport master (
      output stop_pulse, curr_block_start, curr_block_end, curr_block_size, intersect_true,
      input  stop_true, prev_block_start, prev_block_end, prev_block_size, row, next_size,
             next_valid, busy, game_over, win
   );

   modport slave (
      input  stop_pulse, curr_block_start, curr_block_end, curr_block_size, intersect_true,
      output stop_true, prev_block_start, prev_block_end, prev_block_size, row, next_size,
             next_valid, busy, game_over, win
   );
endinterface

// File: rtl/stack_commit.sv
// Trims a stopped block to its overlap with the row below and commits it; spawn pulse 3 cycles after stop.
// No backpressure: stop requests arriving while busy or after game end are dropped.
module stack_commit #(
   parameter int CELL_SHIFT = 3,
   parameter int INIT_SIZE  = 4,
   parameter int NUM_ROWS   = 12
) (
   input logic           clk,
   input logic           resetn,
   stack_commit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, EVAL, CHECK, SPAWN, OVER, WIN} state_t;

   state_t     state;
   logic       stop_true;
   logic [8:0] prev_start;
   logic [8:0] prev_end;
   logic [3:0] prev_size;
   logic [3:0] row;
   logic [3:0] next_size;
   logic       next_valid;
   logic       busy;
   logic       game_over;
   logic       win;

   logic       prev_empty;
   logic [8:0] os;
   logic [8:0] oe;
   logic [9:0] width;
   logic [9:0] cells_w;
   logic [3:0] cells;
   logic [8:0] span;
   logic [8:0] new_end;
   logic [3:0] row_nxt;

   // An empty base (0/0) accepts the moving block as-is.
   always_comb begin
      prev_empty = (prev_start == 9'd0) && (prev_end == 9'd0);
      os = bus.curr_block_start;
      oe = bus.curr_block_end;
      if (!prev_empty) begin
         os = (bus.curr_block_start > prev_start) ? bus.curr_block_start : prev_start;
         oe = (bus.curr_block_end < prev_end) ? bus.curr_block_end : prev_end;
      end
      width = (oe >= os) ? ({1'b0, oe} - {1'b0, os} + 10'd1) : 10'd0;
      cells_w = width >> CELL_SHIFT;
      if (cells_w > {6'd0, bus.curr_block_size}) begin
         cells_w = {6'd0, bus.curr_block_size};
      end
      cells   = cells_w[3:0];
      span    = {5'd0, cells} << CELL_SHIFT;
      new_end = os + span - 9'd1;
      row_nxt = row + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         stop_true  <= 1'b0;
         prev_start <= 9'd0;
         prev_end   <= 9'd0;
         prev_size  <= 4'd0;
         row        <= 4'd0;
         next_size  <= 4'(INIT_SIZE);
         next_valid <= 1'b0;
         busy       <= 1'b0;
         game_over  <= 1'b0;
         win        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.stop_pulse) begin
                  state     <= EVAL;
                  stop_true <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            EVAL: state <= CHECK;
            CHECK: begin
               stop_true <= 1'b0;
               if (!bus.intersect_true || (cells == 4'd0)) begin
                  state     <= OVER;
                  game_over <= 1'b1;
               end else begin
                  prev_start <= os;
                  prev_end   <= new_end;
                  prev_size  <= cells;
                  row        <= row_nxt;
                  next_size  <= cells;
                  if (row_nxt == 4'(NUM_ROWS)) begin
                     state <= WIN;
                     win   <= 1'b1;
                  end else begin
                     state      <= SPAWN;
                     next_valid <= 1'b1;
                  end
               end
            end
            SPAWN: begin
               next_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            OVER, WIN: state <= state;
            default:   state <= IDLE;
         endcase
      end
   end

   assign bus.stop_true        = stop_true;
   assign bus.prev_block_start = prev_start;
   assign bus.prev_block_end   = prev_end;
   assign bus.prev_block_size  = prev_size;
   assign bus.row              = row;
   assign bus.next_size        = next_size;
   assign bus.next_valid       = next_valid;
   assign bus.busy             = busy;
   assign bus.game_over        = game_over;
   assign bus.win              = win;
endmodule

// File: tb/tb_stack_commit.sv
// Directed bench for stack_commit: a stimulus thread queues expected commit outcomes,
// a negedge monitor compares them whenever the DUT spawns, loses or wins.
module tb_stack_commit;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   stack_commit_if bus();

   stack_commit #(.CELL_SHIFT(3), .INIT_SIZE(4), .NUM_ROWS(12)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct packed {
      logic [8:0] ps;
      logic [8:0] pe;
      logic [3:0] psz;
      logic [3:0] row;
      logic [3:0] ns;
      logic       nv;
      logic       go;
      logic       wn;
   } snap_t;

   snap_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic snap_t mk(input int ps, input int pe, input int psz, input int row,
                                input int ns, input bit nv, input bit go, input bit wn);
      snap_t s;
      s.ps = 9'(ps); s.pe = 9'(pe); s.psz = 4'(psz); s.row = 4'(row);
      s.ns = 4'(ns); s.nv = nv; s.go = go; s.wn = wn;
      return s;
   endfunction

   // Monitor: any spawn pulse or rising game_over/win is an output event.
   logic go_d = 1'b0;
   logic win_d = 1'b0;
   always @(negedge clk) begin
      snap_t act;
      snap_t exp;
      act = {bus.prev_block_start, bus.prev_block_end, bus.prev_block_size, bus.row,
             bus.next_size, bus.next_valid, bus.game_over, bus.win};
      if (bus.next_valid || (bus.game_over && !go_d) || (bus.win && !win_d)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got ps=%0d pe=%0d psz=%0d row=%0d ns=%0d nv=%0b go=%0b win=%0b with nothing expected",
                     act.ps, act.pe, act.psz, act.row, act.ns, act.nv, act.go, act.wn);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               failures++;
               $display("FAIL commit_event: got ps=%0d pe=%0d psz=%0d row=%0d ns=%0d nv=%0b go=%0b win=%0b expected ps=%0d pe=%0d psz=%0d row=%0d ns=%0d nv=%0b go=%0b win=%0b",
                        act.ps, act.pe, act.psz, act.row, act.ns, act.nv, act.go, act.wn,
                        exp.ps, exp.pe, exp.psz, exp.row, exp.ns, exp.nv, exp.go, exp.wn);
            end
         end
      end
      go_d  = bus.game_over;
      win_d = bus.win;
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_stop_true"},  32'(bus.stop_true), 0);
      chk({tag, "_next_valid"}, 32'(bus.next_valid), 0);
      chk({tag, "_busy"},       32'(bus.busy), 0);
      chk({tag, "_game_over"},  32'(bus.game_over), 0);
      chk({tag, "_win"},        32'(bus.win), 0);
      chk({tag, "_prev"}, {5'd0, bus.prev_block_start, bus.prev_block_end, bus.prev_block_size}, 0);
      chk({tag, "_row"},        32'(bus.row), 0);
      chk({tag, "_next_size"},  32'(bus.next_size), 4);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   // Issue one stop and check handshake timing; spawn selects spawn vs terminal outcome.
   task automatic do_stop(input int cs, input int ce, input int csz, input bit it,
                          input bit spawn, input bit hold_pulse);
      bus.curr_block_start = 9'(cs);
      bus.curr_block_end   = 9'(ce);
      bus.curr_block_size  = 4'(csz);
      bus.intersect_true   = it;
      bus.stop_pulse       = 1'b1;
      @(posedge clk); #1;
      if (!hold_pulse) bus.stop_pulse = 1'b0;
      chk("eval_stop_true", 32'(bus.stop_true), 1);
      chk("eval_busy", 32'(bus.busy), 1);
      @(posedge clk); #1;
      bus.stop_pulse = 1'b0;
      chk("check_stop_true", 32'(bus.stop_true), 1);
      @(posedge clk); #1;
      chk("post_stop_true", 32'(bus.stop_true), 0);
      chk("spawn_next_valid", 32'(bus.next_valid), 32'(spawn));
      @(posedge clk); #1;
      chk("after_next_valid", 32'(bus.next_valid), 0);
      chk("after_busy", 32'(bus.busy), 32'(!spawn));
      bus.intersect_true = 1'b0;
   endtask

   // A stop request in a terminal state must not start an evaluation.
   task automatic stop_ignored(input string tag);
      bus.stop_pulse = 1'b1;
      @(posedge clk); #1;
      bus.stop_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_stop_true"}, 32'(bus.stop_true), 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bus.stop_pulse = 1'b0;
      bus.curr_block_start = 9'd0;
      bus.curr_block_end = 9'd0;
      bus.curr_block_size = 4'd0;
      bus.intersect_true = 1'b0;

      do_reset();
      chk_reset("reset");

      // First row on empty base, then partial overlap 56..71 -> 2 cells.
      exp_q.push_back(mk(40, 71, 4, 1, 4, 1, 0, 0));
      do_stop(40, 71, 4, 1, 1, 0);
      exp_q.push_back(mk(56, 71, 2, 2, 2, 1, 0, 0));
      do_stop(56, 87, 4, 1, 1, 0);

      // Miss: checker reports no intersection.
      do_reset();
      exp_q.push_back(mk(40, 71, 4, 1, 4, 1, 0, 0));
      do_stop(40, 71, 4, 1, 1, 0);
      exp_q.push_back(mk(40, 71, 4, 1, 4, 0, 1, 0));
      do_stop(80, 111, 4, 0, 0, 0);
      stop_ignored("over");

      // 4 px overlap is less than one cell.
      do_reset();
      exp_q.push_back(mk(40, 71, 4, 1, 4, 1, 0, 0));
      do_stop(40, 71, 4, 1, 1, 0);
      exp_q.push_back(mk(40, 71, 4, 1, 4, 0, 1, 0));
      do_stop(68, 99, 4, 1, 0, 0);

      // Win after twelve exact placements.
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         exp_q.push_back(mk(40, 71, 4, i, 4, (i != 12), 0, (i == 12)));
         do_stop(40, 71, 4, 1, (i != 12), 0);
      end
      stop_ignored("win");

      // Pulse held into EVAL gives a single commit, then reset lands in CHECK.
      do_reset();
      exp_q.push_back(mk(40, 71, 4, 1, 4, 1, 0, 0));
      do_stop(40, 71, 4, 1, 1, 0);
      exp_q.push_back(mk(40, 71, 4, 2, 4, 1, 0, 0));
      do_stop(40, 71, 4, 1, 1, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("single_commit_row", 32'(bus.row), 2);
      bus.curr_block_start = 9'd40;
      bus.curr_block_end = 9'd71;
      bus.curr_block_size = 4'd4;
      bus.intersect_true = 1'b1;
      bus.stop_pulse = 1'b1;
      @(posedge clk); #1;
      bus.stop_pulse = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_stop_true", 32'(bus.stop_true), 1);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      bus.intersect_true = 1'b0;
      chk_reset("mid_reset");
      repeat (4) @(posedge clk);
      #1;
      chk("mid_reset_row", 32'(bus.row), 0);

      chk("expected_queue_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
